uo_capture_uart: RTL and testbench
==================================

// Module: uo_capture_uart
//
// PURPOSE
//   Downstream observation stage for the tt_um_islam_ihfaz_nand user project.
//   Watches the 8-bit dedicated output bus (uo_out) and queues every change of value.
//   Transmits each queued value as a UART 8N1 frame on a single pin, so results are
//   observable on silicon with one uio line.
//   Sits between user_project.uo_out and one uio_out bit in the tile top level.
//
// PARAMETERS
//   DATA_W        8   width of captured bus; also the frame data width
//   FIFO_DEPTH    4   capture queue depth; power of 2, >= 2
//   CLKS_PER_BIT  16  clk cycles per UART bit; >= 2
//
// PORTS
//   clk       in   1                         system clock, all logic on rising edge
//   rst       in   1                         asynchronous, active-high reset
//   ena       in   1                         capture enable (tile ena); 0 = no new captures
//   din       in   DATA_W                    observed bus (uo_out of the NAND design)
//   tx        out  1                         UART serial output, idle high
//   busy      out  1                         1 while a frame is in flight or the queue is non-empty
//   overflow  out  1                         sticky: a change was dropped because the queue was full
//   level     out  $clog2(FIFO_DEPTH)+1      current queue occupancy, 0..FIFO_DEPTH
//
// BEHAVIOUR
//   Reset (async assert, sync release):
//     tx=1, busy=0, overflow=0, level=0, FSM=IDLE, last-value reg=0.
//   Change detect:
//     On each clk edge with ena=1 and din != last, set last<=din and push din.
//     din is not synchronised; the caller guarantees it is clk-synchronous.
//     A first value of 0 after reset is never pushed.
//     With ena=0: last is frozen, nothing is pushed; any frame in progress completes.
//   Queue:
//     Synchronous FIFO, FIFO_DEPTH entries, read/write pointers wrap modulo FIFO_DEPTH.
//     Push while level==FIFO_DEPTH and no pop that cycle: value dropped, overflow<=1,
//     last still updates.
//     Push and pop in the same cycle: always legal (level unchanged), including when full.
//     overflow clears only on rst.
//   Transmit FSM (states IDLE, START, DATA, STOP):
//     IDLE:  tx=1. If level!=0: pop head into shift reg, bit_cnt<=0, go START.
//     START: tx=0 for CLKS_PER_BIT cycles, then go DATA.
//     DATA:  tx=shift[0], LSB first; every CLKS_PER_BIT cycles shift right and bit_cnt++.
//            After DATA_W bits, go STOP.
//     STOP:  tx=1 for CLKS_PER_BIT cycles, then go IDLE.
//     Frame length = (DATA_W+2)*CLKS_PER_BIT cycles. Frames are separated by exactly
//     one IDLE cycle (tx=1).
//   Latency:
//     din change sampled at edge N -> queued at N -> popped at N+1 (if IDLE, queue
//     previously empty) -> tx falls after edge N+1.
//   Counters:
//     Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it resets to 0 on every state entry.
//   busy = (state!=IDLE) | (level!=0), registered-equivalent (no glitching into tx).
//   rst mid-frame: tx returns to 1 immediately (async); the queue is emptied.
//
// TESTING
//   1. Reset, ena=1, din=8'hA5 held -> one frame with bits 0,1,0,1,0,0,1,0,1,1
//      (start, LSB..MSB, stop), each 16 clks; then tx=1, busy=0, level=0.
//   2. din stays 0 after reset for 500 clks -> tx constantly 1, busy=0, no frame.
//   3. din 01->02->03->04->05 on consecutive clks (DEPTH=4) -> frames 01,02,03,04,05 in
//      order, one idle clk between frames, overflow=0 (01 popped before 05 arrives).
//   4. Six changes on consecutive clks while a frame is in flight -> level saturates at 4,
//      overflow=1 and stays 1; exactly 4 queued values plus the in-flight frame are sent.
//   5. ena=0 while din toggles -> no new frames; in-flight frame completes intact;
//      re-enabling with din==last -> no push.
//   6. Assert rst midway through DATA of frame 8'h3C -> tx=1 same cycle, level=0,
//      overflow=0; after release, a new din change is sent as a clean frame.

Source files
------------

// File: rtl/uo_capture_uart.sv
// Change-capture UART: queues every new value seen on din and sends each one as an 8N1 frame on tx.
// Keeps tx idle-high. overflow is sticky and records that a change was dropped because the queue was full.
module uo_capture_uart #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [DATA_W-1:0]             din,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic push, pop, full, wr_en, baud_last;

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign level    = level_q;

  // Change detector and queue bookkeeping; a pop frees a slot for a same-cycle push.
  always_comb begin
    push    = ena && (din != last_q);
    full    = (level_q == LVL_W'(FIFO_DEPTH));
    wr_en   = push && (!full || pop);
    last_d  = push ? din : last_q;
    ovf_d   = ovf_q | (push & full & ~pop);
    wr_d    = wr_en ? (wr_q + PTR_W'(1)) : wr_q;
    rd_d    = pop ? (rd_q + PTR_W'(1)) : rd_q;
    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= din;
    end
  end

  // Transmit FSM: tx_d is the line level for the state being entered, so tx is glitch-free.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUD_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    pop       = 1'b0;
    baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + CNT_W'(1);
          if (bit_q == CNT_W'(DATA_W - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
    busy_d = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

endmodule

// File: tb/tb_uo_capture_uart.sv
// Bench for uo_capture_uart: a frame-timing reference model predicts tx/busy/overflow/level every cycle.
module tb_uo_capture_uart;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CPB   = 16;
  localparam int unsigned FRAME = (DW + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] din;
  logic       tx, busy, overflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending bytes plus the remaining cycles of the frame on the line.
  logic [7:0] mq[$];
  bit         m_idle;
  int         m_rem;
  logic [7:0] m_cur;
  logic [7:0] m_last;
  bit         m_ovf;

  uo_capture_uart #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .tx(tx), .busy(busy), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_idle = 1'b1;
    m_rem  = 0;
    m_cur  = 8'h00;
    m_last = 8'h00;
    m_ovf  = 1'b0;
  endtask

  function automatic logic [5:0] exp_vec();
    int   ph;
    logic t;
    if (m_idle) t = 1'b1;
    else begin
      ph = (FRAME - m_rem) / CPB;
      if (ph == 0) t = 1'b0;
      else if (ph > DW) t = 1'b1;
      else t = m_cur[ph-1];
    end
    return {t, (!m_idle || mq.size() != 0), m_ovf, 3'(mq.size())};
  endfunction

  // One clock edge: advance the model with the inputs present at the edge, then settle.
  task automatic tick();
    logic [7:0] d;
    bit         e, p;
    d = din;
    e = ena;
    @(posedge clk);
    p = m_idle && (mq.size() != 0);
    if (p) begin
      m_cur  = mq.pop_front();
      m_idle = 1'b0;
      m_rem  = FRAME;
    end else if (!m_idle) begin
      m_rem--;
      if (m_rem == 0) m_idle = 1'b1;
    end
    if (e && d != m_last) begin
      m_last = d;
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    din = 8'h00;
    ena = 1'b1;
    rst = 1'b1;
    model_reset();
    #3;
    checks++;
    if ({tx, busy, overflow, level} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", {tx, busy, overflow, level}, 6'b100000);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({tx, busy, overflow, level} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %b required %b", {tx, busy, overflow, level}, exp_vec());
    end
  endtask

  task automatic test_single_frame();
    din = 8'hA5;
    for (int i = 0; i < int'(FRAME) + 10; i++) begin
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL single_frame cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
    checks++;
    if ({tx, busy, level} !== 5'b10000) begin
      errors++;
      $display("FAIL single_frame_end: got %b required %b", {tx, busy, level}, 5'b10000);
    end
  endtask

  task automatic test_idle_zero();
    apply_reset();
    din = 8'h00;
    for (int i = 0; i < 500; i++) begin
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== 6'b100000) begin
        errors++;
        $display("FAIL idle_zero cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, 6'b100000);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int v = 1; v <= 5; v++) begin
      din = 8'(v);
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_push %0d: got %b required %b", v, {tx, busy, overflow, level}, exp_vec());
      end
    end
    for (int i = 0; i < 5 * int'(FRAME) + 20; i++) begin
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
    checks++;
    if ({overflow, busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_no_overflow: got %b required %b", {overflow, busy}, 2'b00);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    din = 8'h11;
    repeat (20) tick();
    for (int k = 0; k < 6; k++) begin
      din = 8'(8'h21 + k);
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_push %0d: got %b required %b", k, {tx, busy, overflow, level}, exp_vec());
      end
    end
    checks++;
    if ({overflow, level} !== 4'b1100) begin
      errors++;
      $display("FAIL ovf_saturate: got %b required %b", {overflow, level}, 4'b1100);
    end
    for (int i = 0; i < 5 * int'(FRAME) + 20; i++) begin
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL ovf cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
    checks++;
    if ({overflow, busy, level} !== 5'b10000) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required %b", {overflow, busy, level}, 5'b10000);
    end
  endtask

  task automatic test_ena_gate();
    apply_reset();
    din = 8'h5A;
    repeat (30) tick();
    ena = 1'b0;
    for (int i = 0; i < int'(FRAME) + 40; i++) begin
      din = 8'($urandom);
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL ena_gate cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
    din = 8'h5A;
    ena = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== 6'b100000) begin
        errors++;
        $display("FAIL reenable_same cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, 6'b100000);
      end
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    din = 8'h3C;
    for (int i = 0; i < int'(CPB) * 5; i++) begin
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL pre_rst cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({tx, busy, overflow, level} !== 6'b100000) begin
      errors++;
      $display("FAIL async_rst: got %b required %b", {tx, busy, overflow, level}, 6'b100000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    din = 8'h81;
    for (int i = 0; i < int'(FRAME) + 10; i++) begin
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL post_rst cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0 || (i > 2000 && $urandom_range(0, 3) == 0)) din = 8'($urandom);
      tick();
      checks++;
      if ({tx, busy, overflow, level} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b required %b", i, {tx, busy, overflow, level}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_idle_zero();
    test_back_to_back();
    test_overflow();
    test_ena_gate();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
